// File: rtl/rv_div_pkg.sv
// ============================================================================
// Module   : rv_div_pkg
// Purpose  : Shared constants and types for the rv_div64 iterative divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_div_pkg;

  localparam int XLEN    = 64;
  localparam int ITER_64 = 64;
  localparam int ITER_32 = 32;
  localparam int CNT_W   = 7;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } div_state_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

endpackage

`default_nettype wire

// File: rtl/rv_div64_step.sv
// ============================================================================
// Module   : rv_div64_step
// Purpose  : One combinational restoring shift-subtract division iteration.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_div64_step
  import rv_div_pkg::*;
(
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_diff;
  logic          w_fits;

  // The shifted remainder needs one extra bit: an unsigned divisor may use all 64 bits.
  always_comb begin
    w_shift = {rem_in, quo_in[XLEN-1]};
    w_diff  = w_shift - {1'b0, divisor};
    w_fits  = (w_shift >= {1'b0, divisor});
    rem_out = w_fits ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
    quo_out = {quo_in[XLEN-2:0], w_fits};
  end

endmodule

`default_nettype wire

// File: rtl/rv_div64.sv
// ============================================================================
// Module   : rv_div64
// Purpose  : Iterative RISC-V DIV/DIVU/REM/REMU unit, one quotient bit per
//            cycle. Define RV_DIV_WORD_EN to enable the 32-bit W variants.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_div64
  import rv_div_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [1:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] result
);

  div_state_t       r_state;
  div_state_t       w_state_nxt;

  logic [XLEN-1:0]  r_quo;
  logic [XLEN-1:0]  r_rem;
  logic [XLEN-1:0]  r_dvs;
  logic [CNT_W-1:0] r_cnt;
  logic             r_word;
  logic             r_is_rem;
  logic             r_neg_q;
  logic             r_neg_r;

  logic             w_word;
  logic             w_signed;
  logic             w_is_rem;
  logic [XLEN-1:0]  w_a;
  logic [XLEN-1:0]  w_b;
  logic [XLEN-1:0]  w_min;
  logic             w_neg_a;
  logic             w_neg_b;
  logic [XLEN-1:0]  w_mag_a;
  logic [XLEN-1:0]  w_mag_b;
  logic             w_div0;
  logic             w_ovf;
  logic             w_special;
  logic [XLEN-1:0]  w_special_raw;
  logic [XLEN-1:0]  w_special_res;
  logic             w_accept;
  logic             w_last;

  logic [XLEN-1:0]  w_step_rem;
  logic [XLEN-1:0]  w_step_quo;
  logic [XLEN-1:0]  w_q_mag;
  logic [XLEN-1:0]  w_q_fix;
  logic [XLEN-1:0]  w_r_fix;
  logic [XLEN-1:0]  w_sel;
  logic [XLEN-1:0]  w_final_res;

`ifdef RV_DIV_WORD_EN
  assign w_word = word;
`else
  logic w_unused_word;
  assign w_unused_word = word;
  assign w_word        = 1'b0;
`endif

  // Operand conditioning, magnitudes and special-case detection at accept.
  always_comb begin
    w_signed = ~op[0];
    w_is_rem = op[1];
    if (w_word) begin
      w_a   = w_signed ? sext32(rs1[31:0]) : {{(XLEN-32){1'b0}}, rs1[31:0]};
      w_b   = w_signed ? sext32(rs2[31:0]) : {{(XLEN-32){1'b0}}, rs2[31:0]};
      w_min = {{(XLEN-31){1'b1}}, 31'b0};
    end else begin
      w_a   = rs1;
      w_b   = rs2;
      w_min = {1'b1, {(XLEN-1){1'b0}}};
    end
    w_neg_a   = w_signed & w_a[XLEN-1];
    w_neg_b   = w_signed & w_b[XLEN-1];
    w_mag_a   = w_neg_a ? -w_a : w_a;
    w_mag_b   = w_neg_b ? -w_b : w_b;
    w_div0    = (w_b == '0);
    w_ovf     = w_signed & (w_a == w_min) & (w_b == '1);
    w_special = w_div0 | w_ovf;
    if (w_div0) begin
      w_special_raw = w_is_rem ? w_a : '1;
    end else begin
      w_special_raw = w_is_rem ? '0 : w_a;
    end
    w_special_res = w_word ? sext32(w_special_raw[31:0]) : w_special_raw;
  end

  rv_div64_step u_step (
    .rem_in  (r_rem),
    .quo_in  (r_quo),
    .divisor (r_dvs),
    .rem_out (w_step_rem),
    .quo_out (w_step_quo)
  );

  // Sign fix-up applied to the outputs of the final iteration.
  always_comb begin
    w_last      = (r_cnt == (r_word ? CNT_W'(ITER_32 - 1) : CNT_W'(ITER_64 - 1)));
    w_q_mag     = r_word ? {{(XLEN-32){1'b0}}, w_step_quo[31:0]} : w_step_quo;
    w_q_fix     = r_neg_q ? -w_q_mag : w_q_mag;
    w_r_fix     = r_neg_r ? -w_step_rem : w_step_rem;
    w_sel       = r_is_rem ? w_r_fix : w_q_fix;
    w_final_res = r_word ? sext32(w_sel[31:0]) : w_sel;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    busy        = (r_state == CALC);
    valid       = (r_state == DONE);
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = w_special ? DONE : CALC;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      CALC: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (flush) begin
      w_state_nxt = IDLE;
      w_accept    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_quo    <= '0;
      r_rem    <= '0;
      r_dvs    <= '0;
      r_cnt    <= '0;
      r_word   <= 1'b0;
      r_is_rem <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      result   <= '0;
    end else if (!flush) begin
      if (w_accept) begin
        r_word   <= w_word;
        r_is_rem <= w_is_rem;
        r_neg_q  <= w_neg_a ^ w_neg_b;
        r_neg_r  <= w_neg_a;
        // W operands sit in the top half so 32 shifts bring the quotient to the low half.
        r_quo    <= w_word ? {w_mag_a[31:0], {(XLEN-32){1'b0}}} : w_mag_a;
        r_rem    <= '0;
        r_dvs    <= w_mag_b;
        r_cnt    <= '0;
        if (w_special) begin
          result <= w_special_res;
        end
      end else if (r_state == CALC) begin
        r_quo <= w_step_quo;
        r_rem <= w_step_rem;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          result <= w_final_res;
        end
      end
    end
  end

endmodule

`default_nettype wire
